// File: rtl/calc_scheduler_pkg.sv
// Shared types and defaults for the calc_scheduler token/result router.
// Holds the arbitration FSM state type, width defaults and the default
// end-of-expression operator code.
package calc_sched_pkg;

    localparam int          TOKEN_W_DEF   = 32;
    localparam int          RESULT_W_DEF  = 64;
    localparam int          TAG_DEPTH_DEF = 4;
    localparam int          TIMEOUT_DEF   = 255;
    localparam logic [31:0] END_CODE_DEF  = 32'd61;   // '='

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } sched_state_t;

    // Index of the requester to grant. On a tie the one not served last wins.
    function automatic logic pick_winner(input logic stb0, input logic stb1,
                                         input logic last_served);
        if (stb0 && stb1) begin
            return ~last_served;
        end else if (stb0) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/calc_scheduler_tag_fifo.sv
// Owner-tag FIFO for calc_scheduler: one bit per outstanding expression,
// recording which requester started it so results route back in order.
// A push and a pop on the same edge leave the occupancy unchanged, even
// when the FIFO is full (the pop frees the slot the push takes).
module tag_fifo
    import calc_sched_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage, pointers and occupancy; reset discards every stored tag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_scheduler.sv
// calc_scheduler: arbitrates two token requesters onto one converter stream,
// one whole expression at a time, and routes calculator results back to the
// requester that started each expression, in start order, with no added
// latency on any path.
//
// Optional feature: define CALC_SCHED_WATCHDOG_EN to enable an idle watchdog
// that terminates a stalled expression by injecting END_CODE and pulsing
// ERR_STB. Without it the grant is held indefinitely and ERR_STB is 0.
//
// state  | meaning
// IDLE   | no owner; grant a requester when a tag slot is free
// GRANT0 | requester 0 owns the converter until its END_CODE transfers
// GRANT1 | requester 1 owns the converter until its END_CODE transfers
module calc_scheduler
    import calc_sched_pkg::*;
#(
    parameter int                 TOKEN_W   = TOKEN_W_DEF,
    parameter int                 RESULT_W  = RESULT_W_DEF,
    parameter int                 TAG_DEPTH = TAG_DEPTH_DEF,
    parameter logic [TOKEN_W-1:0] END_CODE  = TOKEN_W'(END_CODE_DEF),
    parameter int                 TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ0_STB,
    input  logic [TOKEN_W-1:0]  REQ0_DAT,
    input  logic                REQ0_OP,
    output logic                REQ0_ACK,
    input  logic                REQ1_STB,
    input  logic [TOKEN_W-1:0]  REQ1_DAT,
    input  logic                REQ1_OP,
    output logic                REQ1_ACK,
    output logic                RES0_STB,
    output logic [RESULT_W-1:0] RES0_DAT,
    input  logic                RES0_ACK,
    output logic                RES1_STB,
    output logic [RESULT_W-1:0] RES1_DAT,
    input  logic                RES1_ACK,
    output logic                CONV_STB,
    output logic [TOKEN_W-1:0]  CONV_DAT,
    output logic                CONV_OP,
    input  logic                CONV_ACK,
    input  logic                CALC_STB,
    input  logic [RESULT_W-1:0] CALC_DAT,
    output logic                CALC_ACK,
    output logic                ERR_STB
);

    sched_state_t state;
    sched_state_t state_nxt;
    logic         last_served;
    logic         granted;
    logic         owner;
    logic         conv_xfer;
    logic         end_xfer;
    logic         push;
    logic         push_tag;
    logic         pop;
    logic         head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         inject;

    assign granted   = (state == GRANT0) || (state == GRANT1);
    assign owner     = (state == GRANT1);
    assign conv_xfer = CONV_STB && CONV_ACK;
    assign end_xfer  = conv_xfer && CONV_OP && (CONV_DAT == END_CODE);

`ifdef CALC_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign inject  = granted && (wd_cnt == WD_W'(TIMEOUT));
    assign ERR_STB = err_q;

    // Idle-cycle counter: cleared on any converter transfer or outside a
    // grant, saturates at TIMEOUT where the END_CODE injection takes over.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= inject && CONV_ACK;
            if (!granted || conv_xfer) begin
                wd_cnt <= '0;
            end else if (!inject) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end
`else
    assign inject  = 1'b0;
    assign ERR_STB = 1'b0;
`endif

    // State register and last-served pointer (1 so requester 0 wins the first tie).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state <= state_nxt;
            if (granted && end_xfer) begin
                last_served <= owner;
            end
        end
    end

    // Next state: grant only with a free tag slot; release on END_CODE transfer.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_tag  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_full && (REQ0_STB || REQ1_STB)) begin
                    push      = 1'b1;
                    push_tag  = pick_winner(REQ0_STB, REQ1_STB, last_served);
                    state_nxt = push_tag ? GRANT1 : GRANT0;
                end
            end
            GRANT0, GRANT1: begin
                if (end_xfer) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Token path: the owner is wired straight through to the converter.
    // A full tag FIFO only blocks new grants; an expression already granted
    // has its tag stored and is allowed to finish.
    always_comb begin
        CONV_STB = 1'b0;
        CONV_DAT = '0;
        CONV_OP  = 1'b0;
        REQ0_ACK = 1'b0;
        REQ1_ACK = 1'b0;
        if (granted) begin
            if (inject) begin
                CONV_STB = 1'b1;
                CONV_OP  = 1'b1;
                CONV_DAT = END_CODE;
            end else if (owner) begin
                CONV_STB = REQ1_STB;
                CONV_DAT = REQ1_DAT;
                CONV_OP  = REQ1_OP;
                REQ1_ACK = CONV_ACK;
            end else begin
                CONV_STB = REQ0_STB;
                CONV_DAT = REQ0_DAT;
                CONV_OP  = REQ0_OP;
                REQ0_ACK = CONV_ACK;
            end
        end
    end

    // Result path: the FIFO head owns the calculator output; with no
    // outstanding tag, results are acked and dropped.
    always_comb begin
        RES0_STB = 1'b0;
        RES0_DAT = '0;
        RES1_STB = 1'b0;
        RES1_DAT = '0;
        CALC_ACK = 1'b1;
        pop      = 1'b0;
        if (!fifo_empty) begin
            if (head) begin
                RES1_STB = CALC_STB;
                RES1_DAT = CALC_DAT;
                CALC_ACK = RES1_ACK;
            end else begin
                RES0_STB = CALC_STB;
                RES0_DAT = CALC_DAT;
                CALC_ACK = RES0_ACK;
            end
            pop = CALC_STB && CALC_ACK;
        end
    end

    tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   (push_tag),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_calc_scheduler.sv
// Self-checking bench for calc_scheduler: directed scenarios followed by a
// randomized run scored against a transaction-level model (expression start
// order queue, per-requester token queues, no-interleave rule).
// Honours CALC_SCHED_WATCHDOG_EN (watchdog limit of 8 in that build).
module tb_calc_scheduler;

    localparam int          TW    = 32;
    localparam int          RW    = 64;
    localparam int          DEPTH = 4;
    localparam logic [31:0] EQ    = 32'd61;
`ifdef CALC_SCHED_WATCHDOG_EN
    localparam int TO        = 8;
    localparam int STALL_PCT = 0;
`else
    localparam int TO        = 255;
    localparam int STALL_PCT = 25;
`endif
    localparam int N_PER_REQ = 25;

    typedef struct {
        logic [31:0] dat;
        logic        op;
    } tok_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ0_STB, REQ0_OP, REQ0_ACK;
    logic [TW-1:0] REQ0_DAT;
    logic          REQ1_STB, REQ1_OP, REQ1_ACK;
    logic [TW-1:0] REQ1_DAT;
    logic          RES0_STB, RES0_ACK, RES1_STB, RES1_ACK;
    logic [RW-1:0] RES0_DAT, RES1_DAT;
    logic          CONV_STB, CONV_OP, CONV_ACK;
    logic [TW-1:0] CONV_DAT;
    logic          CALC_STB, CALC_ACK, ERR_STB;
    logic [RW-1:0] CALC_DAT;

    int n_chk  = 0;
    int n_pass = 0;
    int owner_q[$];
    tok_t tq0[$];
    tok_t tq1[$];

    always #5 CLK = ~CLK;

    calc_scheduler #(
        .TOKEN_W (TW), .RESULT_W (RW), .TAG_DEPTH (DEPTH),
        .END_CODE (EQ), .TIMEOUT (TO)
    ) dut (
        .CLK (CLK), .RST (RST),
        .REQ0_STB (REQ0_STB), .REQ0_DAT (REQ0_DAT), .REQ0_OP (REQ0_OP), .REQ0_ACK (REQ0_ACK),
        .REQ1_STB (REQ1_STB), .REQ1_DAT (REQ1_DAT), .REQ1_OP (REQ1_OP), .REQ1_ACK (REQ1_ACK),
        .RES0_STB (RES0_STB), .RES0_DAT (RES0_DAT), .RES0_ACK (RES0_ACK),
        .RES1_STB (RES1_STB), .RES1_DAT (RES1_DAT), .RES1_ACK (RES1_ACK),
        .CONV_STB (CONV_STB), .CONV_DAT (CONV_DAT), .CONV_OP (CONV_OP), .CONV_ACK (CONV_ACK),
        .CALC_STB (CALC_STB), .CALC_DAT (CALC_DAT), .CALC_ACK (CALC_ACK),
        .ERR_STB (ERR_STB)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input int r, input logic stb, input logic [31:0] d, input logic op);
        if (r == 0) begin
            REQ0_STB = stb; REQ0_DAT = d; REQ0_OP = op;
        end else begin
            REQ1_STB = stb; REQ1_DAT = d; REQ1_OP = op;
        end
    endtask

    task automatic idle_inputs();
        drive_req(0, 1'b0, 32'd0, 1'b0);
        drive_req(1, 1'b0, 32'd0, 1'b0);
        CONV_ACK = 1'b1;
        RES0_ACK = 1'b0;
        RES1_ACK = 1'b0;
        CALC_STB = 1'b0;
        CALC_DAT = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        tick();
        tick();
        RST = 1'b0;
        owner_q.delete();
        tick();
    endtask

    // Offer one token from requester r and wait (bounded) for its transfer.
    task automatic send_tok(input int r, input logic [31:0] d, input logic op, output int waits);
        logic ack;
        logic oack;
        drive_req(r, 1'b1, d, op);
        waits = 0;
        #1;
        ack = (r == 0) ? REQ0_ACK : REQ1_ACK;
        while (ack !== 1'b1 && waits < 50) begin
            tick();
            #1;
            waits++;
            ack = (r == 0) ? REQ0_ACK : REQ1_ACK;
        end
        oack = (r == 0) ? REQ1_ACK : REQ0_ACK;
        chk("tok_acked", 64'(ack), 64'(1));
        chk("other_ack_low", 64'(oack), 64'(0));
        chk("conv_dat", 64'(CONV_DAT), 64'(d));
        chk("conv_op", 64'(CONV_OP), 64'(op));
        tick();
        drive_req(r, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic send_expr(input int r, input logic [31:0] a, input logic [31:0] opc,
                             input logic [31:0] b);
        int w;
        send_tok(r, a, 1'b0, w);
        owner_q.push_back(r);
        send_tok(r, opc, 1'b1, w);
        send_tok(r, b, 1'b0, w);
        send_tok(r, EQ, 1'b1, w);
    endtask

    // Return one result; the model says it belongs to the oldest started expression.
    task automatic return_result(input logic [63:0] v);
        int h;
        h = (owner_q.size() > 0) ? owner_q.pop_front() : 0;
        CALC_STB = 1'b1;
        CALC_DAT = v;
        RES0_ACK = 1'b1;
        RES1_ACK = 1'b1;
        #1;
        chk("res_stb_owner", 64'(h ? RES1_STB : RES0_STB), 64'(1));
        chk("res_dat_owner", h ? RES1_DAT : RES0_DAT, v);
        chk("res_stb_other", 64'(h ? RES0_STB : RES1_STB), 64'(0));
        chk("calc_ack", 64'(CALC_ACK), 64'(1));
        tick();
        CALC_STB = 1'b0;
        CALC_DAT = '0;
        RES0_ACK = 1'b0;
        RES1_ACK = 1'b0;
    endtask

    task automatic gen_expr(input int r);
        tok_t t;
        int   n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            t.dat = 32'($urandom_range(0, 1000));
            t.op  = 1'b0;
            if (r == 0) tq0.push_back(t); else tq1.push_back(t);
            t.dat = 32'd42 + 32'($urandom_range(0, 5));
            t.op  = 1'b1;
            if (r == 0) tq0.push_back(t); else tq1.push_back(t);
        end
        t.dat = 32'($urandom_range(0, 1000));
        t.op  = 1'b0;
        if (r == 0) tq0.push_back(t); else tq1.push_back(t);
        t.dat = EQ;
        t.op  = 1'b1;
        if (r == 0) tq0.push_back(t); else tq1.push_back(t);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        int   w;
        int   c;
        logic err_seen;

        // Reset forces outputs low immediately, even with live inputs.
        RST = 1'b1;
        idle_inputs();
        REQ0_STB = 1'b1;
        CALC_STB = 1'b1;
        CALC_DAT = 64'd5;
        RES0_ACK = 1'b1;
        #1;
        chk("rst_conv_stb", 64'(CONV_STB), 64'(0));
        chk("rst_req0_ack", 64'(REQ0_ACK), 64'(0));
        chk("rst_res0_stb", 64'(RES0_STB), 64'(0));
        chk("rst_res1_stb", 64'(RES1_STB), 64'(0));
        chk("rst_calc_ack", 64'(CALC_ACK), 64'(1));
        chk("rst_err", 64'(ERR_STB), 64'(0));
        do_reset();

        // 3 + 4 = from requester 0, result 7 to requester 0 only.
        send_expr(0, 32'd3, 32'd43, 32'd4);
        chk("idle_after_eq", 64'(CONV_STB), 64'(0));
        return_result(64'd7);
        chk("empty_calc_ack", 64'(CALC_ACK), 64'(1));

        // Tie after reset goes to requester 0, then to requester 1.
        do_reset();
        drive_req(1, 1'b1, 32'd2, 1'b0);
        send_tok(0, 32'd1, 1'b0, w);
        chk("tie_req0_first", 64'(w), 64'(1));
        owner_q.push_back(0);
        send_tok(0, EQ, 1'b1, w);
        drive_req(0, 1'b1, 32'd3, 1'b0);
        send_tok(1, 32'd2, 1'b0, w);
        chk("tie_req1_next", 64'(w), 64'(1));
        owner_q.push_back(1);
        // Requester 1 pauses mid-expression; requester 0 must stay blocked.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req0_ack", 64'(REQ0_ACK), 64'(0));
            chk("hold_conv_stb", 64'(CONV_STB), 64'(0));
        end
        send_tok(1, 32'd43, 1'b1, w);
        send_tok(1, 32'd6, 1'b0, w);
        send_tok(1, EQ, 1'b1, w);
        send_tok(0, 32'd3, 1'b0, w);
        chk("req0_after_req1_eq", 64'(w), 64'(1));
        owner_q.push_back(0);
        send_tok(0, EQ, 1'b1, w);
        return_result(64'd11);
        return_result(64'd12);
        return_result(64'd13);

        // Four outstanding expressions fill the tag FIFO.
        for (int i = 0; i < 4; i++) send_expr(i % 2, 32'(100 + i), 32'd45, 32'd1);
        drive_req(0, 1'b1, 32'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_no_ack", 64'(REQ0_ACK), 64'(0));
            chk("full_no_conv", 64'(CONV_STB), 64'(0));
        end
        return_result(64'd10);
        send_tok(0, 32'd7, 1'b0, w);
        chk("grant_after_pop", 64'(w), 64'(1));
        owner_q.push_back(0);
        send_tok(0, EQ, 1'b1, w);
        return_result(64'd20);
        return_result(64'd30);
        return_result(64'd40);
        return_result(64'd50);

        // Reset mid-expression drops the partial expression and its tag.
        do_reset();
        send_tok(0, 32'd5, 1'b0, w);
        send_tok(0, 32'd42, 1'b1, w);
        drive_req(0, 1'b1, 32'd6, 1'b0);
        #1;
        chk("mid_expr_ack", 64'(REQ0_ACK), 64'(1));
        RST = 1'b1;
        #1;
        chk("rst_mid_conv", 64'(CONV_STB), 64'(0));
        chk("rst_mid_ack", 64'(REQ0_ACK), 64'(0));
        chk("rst_mid_res0", 64'(RES0_STB), 64'(0));
        chk("rst_mid_calc_ack", 64'(CALC_ACK), 64'(1));
        drive_req(0, 1'b0, 32'd0, 1'b0);
        tick();
        RST = 1'b0;
        owner_q.delete();
        tick();
        CALC_STB = 1'b1;
        CALC_DAT = 64'd9;
        RES0_ACK = 1'b1;
        #1;
        chk("drop_calc_ack", 64'(CALC_ACK), 64'(1));
        chk("drop_res0_stb", 64'(RES0_STB), 64'(0));
        chk("drop_res1_stb", 64'(RES1_STB), 64'(0));
        tick();
        CALC_STB = 1'b0;
        RES0_ACK = 1'b0;
        send_expr(1, 32'd1, 32'd43, 32'd2);
        return_result(64'd33);

        // Stall after one token.
        do_reset();
        send_tok(0, 32'd2, 1'b0, w);
        owner_q.push_back(0);
`ifdef CALC_SCHED_WATCHDOG_EN
        c = 0;
        while (CONV_STB !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        chk("wd_delay", 64'(c), 64'(TO));
        drive_req(0, 1'b1, 32'd5, 1'b0);
        #1;
        chk("wd_conv_dat", 64'(CONV_DAT), 64'(EQ));
        chk("wd_conv_op", 64'(CONV_OP), 64'(1));
        chk("wd_req0_ack", 64'(REQ0_ACK), 64'(0));
        chk("wd_err_before", 64'(ERR_STB), 64'(0));
        drive_req(0, 1'b0, 32'd0, 1'b0);
        tick();
        chk("wd_err_pulse", 64'(ERR_STB), 64'(1));
        chk("wd_idle", 64'(CONV_STB), 64'(0));
        tick();
        chk("wd_err_once", 64'(ERR_STB), 64'(0));
        err_seen = 1'b0;
`else
        err_seen = 1'b0;
        c = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ERR_STB !== 1'b0 || CONV_STB !== 1'b0) err_seen = 1'b1;
        end
        chk("no_wd_quiet", 64'(err_seen), 64'(0));
        send_tok(0, EQ, 1'b1, w);
        chk("no_wd_grant_held", 64'(w), 64'(0));
`endif
        return_result(64'd77);

        // Randomized traffic scored against the transaction model.
        do_reset();
        begin
            int   gen_left[2];
            int   n_total;
            int   n_done;
            int   n_res;
            int   cur_owner;
            int   r;
            int   h;
            logic x0;
            logic x1;
            logic calc_pend;
            logic [63:0] calc_val;
            tok_t t;
            gen_left[0] = N_PER_REQ;
            gen_left[1] = N_PER_REQ;
            n_total = 0; n_done = 0; n_res = 0;
            cur_owner = -1;
            calc_pend = 1'b0;
            calc_val = '0;
            tq0.delete();
            tq1.delete();
            for (int cyc = 0; cyc < 20000; cyc++) begin
                if (gen_left[0] == 0 && gen_left[1] == 0 && tq0.size() == 0 &&
                    tq1.size() == 0 && n_res == n_total) break;
                @(negedge CLK);
                x0 = REQ0_STB && REQ0_ACK;
                x1 = REQ1_STB && REQ1_ACK;
                if (x0 || x1) begin
                    r = x1 ? 1 : 0;
                    chk("single_src", 64'(x0 && x1), 64'(0));
                    t = (r == 1) ? tq1[0] : tq0[0];
                    chk("rnd_conv_xfer", 64'(CONV_STB && CONV_ACK), 64'(1));
                    chk("rnd_conv_dat", 64'(CONV_DAT), 64'(t.dat));
                    chk("rnd_conv_op", 64'(CONV_OP), 64'(t.op));
                    if (cur_owner < 0) begin
                        chk("tag_room", 64'(owner_q.size() < DEPTH), 64'(1));
                        owner_q.push_back(r);
                        cur_owner = r;
                    end else begin
                        chk("no_split", 64'(r), 64'(cur_owner));
                    end
                    if (t.op && t.dat == EQ) begin
                        cur_owner = -1;
                        n_done++;
                    end
                    if (r == 1) void'(tq1.pop_front()); else void'(tq0.pop_front());
                end
                if (CALC_STB) begin
                    h = owner_q[0];
                    chk("rnd_res_stb", 64'(h ? RES1_STB : RES0_STB), 64'(1));
                    chk("rnd_res_dat", h ? RES1_DAT : RES0_DAT, calc_val);
                    chk("rnd_res_other", 64'(h ? RES0_STB : RES1_STB), 64'(0));
                    chk("rnd_calc_ack", 64'(CALC_ACK), 64'(h ? RES1_ACK : RES0_ACK));
                    if (CALC_ACK) begin
                        void'(owner_q.pop_front());
                        n_res++;
                        calc_pend = 1'b0;
                    end
                end
                chk("rnd_no_err", 64'(ERR_STB), 64'(0));
                tick();
                for (int q = 0; q < 2; q++) begin
                    if (((q == 0) ? tq0.size() : tq1.size()) == 0 && gen_left[q] > 0 &&
                        $urandom_range(0, 99) < 40) begin
                        gen_expr(q);
                        gen_left[q]--;
                        n_total++;
                    end
                end
                REQ0_STB = (tq0.size() > 0) && ($urandom_range(0, 99) >= STALL_PCT);
                REQ0_DAT = (tq0.size() > 0) ? tq0[0].dat : 32'd0;
                REQ0_OP  = (tq0.size() > 0) ? tq0[0].op : 1'b0;
                REQ1_STB = (tq1.size() > 0) && ($urandom_range(0, 99) >= STALL_PCT);
                REQ1_DAT = (tq1.size() > 0) ? tq1[0].dat : 32'd0;
                REQ1_OP  = (tq1.size() > 0) ? tq1[0].op : 1'b0;
                CONV_ACK = ($urandom_range(0, 99) >= STALL_PCT);
                RES0_ACK = ($urandom_range(0, 99) < 70);
                RES1_ACK = ($urandom_range(0, 99) < 70);
                if (!calc_pend && n_done > n_res && $urandom_range(0, 99) < 50) begin
                    calc_pend = 1'b1;
                    calc_val  = {32'($urandom), 32'($urandom)};
                end
                CALC_STB = calc_pend;
                CALC_DAT = calc_pend ? calc_val : 64'd0;
            end
            chk("rnd_all_results", 64'(n_res), 64'(2 * N_PER_REQ));
            chk("rnd_tokens_drained", 64'(tq0.size() + tq1.size()), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
